// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a FIFO prefetch queue between instruction memory and ID.
// Optional redirect alignment check is enabled by defining IF_ALIGN_CHECK_EN.
module if_fetch_queue #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'hBFC00000,
  parameter logic [31:0] PC_INCR     = 32'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] Instr_address_2IM,
  output logic        Fetch_Req_OUT,
  input  logic [31:0] Instr1_fIM,
  input  logic        hit,
  input  logic        Request_Alt_PC,
  input  logic [31:0] Alt_PC,
  input  logic        STALL,
  output logic        Instr_Valid_OUT,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4,
  output logic        Misaligned_OUT
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t             q_mem [QUEUE_DEPTH];
  logic [31:0]        fetch_pc;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [31:0]        alt_pc_eff;
  logic               push;
  logic               pop;
  logic [PTR_W-1:0]   wr_idx;
  entry_t             head;

  // Redirect target as presented to memory and stored in the queue
`ifdef IF_ALIGN_CHECK_EN
  logic alt_misaligned;
  logic misaligned_q;

  assign alt_pc_eff     = {Alt_PC[31:2], 2'b00};
  assign alt_misaligned = |Alt_PC[1:0];
  assign Misaligned_OUT = misaligned_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      misaligned_q <= 1'b0;
    end else if (Request_Alt_PC) begin
      misaligned_q <= alt_misaligned;
    end
  end
`else
  assign alt_pc_eff     = Alt_PC;
  assign Misaligned_OUT = 1'b0;
`endif

  assign Instr_address_2IM = Request_Alt_PC ? alt_pc_eff : fetch_pc;
  assign Fetch_Req_OUT     = Request_Alt_PC | (count != CNT_W'(QUEUE_DEPTH));
  assign push              = Fetch_Req_OUT & hit;
  assign pop               = Instr_Valid_OUT & ~STALL & ~Request_Alt_PC;
  assign wr_idx            = Request_Alt_PC ? '0 : wr_ptr;

  // Head presentation; forced to fixed values while the queue is empty
  assign head            = q_mem[rd_ptr];
  assign Instr_Valid_OUT = (count != '0);
  assign Instr1_OUT      = Instr_Valid_OUT ? head.instr : 32'h0;
  assign Instr_PC_OUT    = Instr_Valid_OUT ? head.pc : 32'h0;
  assign Instr_PC_Plus4  = Instr_PC_OUT + PC_INCR;

  // Queue storage is deliberately left unreset
  always_ff @(posedge CLK) begin
    if (push) begin
      q_mem[wr_idx] <= '{instr: Instr1_fIM,
                         pc:    (Request_Alt_PC ? alt_pc_eff : fetch_pc)};
    end
  end

  // Fetch PC, pointers and occupancy; a redirect overrides push and pop
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (Request_Alt_PC) begin
      rd_ptr <= '0;
      if (hit) begin
        wr_ptr   <= PTR_W'(1);
        count    <= CNT_W'(1);
        fetch_pc <= alt_pc_eff + PC_INCR;
      end else begin
        wr_ptr   <= '0;
        count    <= '0;
        fetch_pc <= alt_pc_eff;
      end
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + PC_INCR;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: fetched entries are queued as expected head values.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'hBFC00000;
  localparam logic [31:0] INCR  = 32'd4;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] Instr_address_2IM;
  logic        Fetch_Req_OUT;
  logic [31:0] Instr1_fIM = '0;
  logic        hit = 1'b0;
  logic        Request_Alt_PC = 1'b0;
  logic [31:0] Alt_PC = '0;
  logic        STALL = 1'b0;
  logic        Instr_Valid_OUT;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr_PC_OUT;
  logic [31:0] Instr_PC_Plus4;
  logic        Misaligned_OUT;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [31:0] m_pc  = RPC;
  logic        m_mis = 1'b0;

  if_fetch_queue #(.QUEUE_DEPTH(DEPTH), .RESET_PC(RPC), .PC_INCR(INCR)) dut (
    .CLK(CLK), .RESET(RESET),
    .Instr_address_2IM(Instr_address_2IM), .Fetch_Req_OUT(Fetch_Req_OUT),
    .Instr1_fIM(Instr1_fIM), .hit(hit),
    .Request_Alt_PC(Request_Alt_PC), .Alt_PC(Alt_PC), .STALL(STALL),
    .Instr_Valid_OUT(Instr_Valid_OUT), .Instr1_OUT(Instr1_OUT),
    .Instr_PC_OUT(Instr_PC_OUT), .Instr_PC_Plus4(Instr_PC_Plus4),
    .Misaligned_OUT(Misaligned_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alt_eff(input logic [31:0] a);
`ifdef IF_ALIGN_CHECK_EN
    return {a[31:2], 2'b00};
`else
    return a;
`endif
  endfunction

  // Compare every visible output against the model, then advance the model over the coming edge
  task automatic step(input logic h, input logic st, input logic rd, input logic [31:0] alt);
    logic [31:0] ins;
    logic [31:0] exp_addr;
    logic        do_pop;
    logic        do_push;
    @(negedge CLK);
    ins = $urandom;
    hit = h; STALL = st; Request_Alt_PC = rd; Alt_PC = alt; Instr1_fIM = ins;
    #1;
    exp_addr = rd ? alt_eff(alt) : m_pc;
    check("addr", Instr_address_2IM, exp_addr);
    check("req", 32'(Fetch_Req_OUT), 32'(rd | (sb.size() != DEPTH)));
    check("valid", 32'(Instr_Valid_OUT), 32'(sb.size() != 0));
    check("mis", 32'(Misaligned_OUT), 32'(m_mis));
    if (sb.size() != 0) begin
      check("head_instr", Instr1_OUT, sb[0].instr);
      check("head_pc", Instr_PC_OUT, sb[0].pc);
      check("head_plus4", Instr_PC_Plus4, sb[0].pc + INCR);
    end else begin
      check("idle_instr", Instr1_OUT, 32'h0);
      check("idle_pc", Instr_PC_OUT, 32'h0);
      check("idle_plus4", Instr_PC_Plus4, INCR);
    end
    if (rd) begin
      sb.delete();
      if (h) begin
        sb.push_back('{instr: ins, pc: alt_eff(alt)});
        m_pc = alt_eff(alt) + INCR;
      end else begin
        m_pc = alt_eff(alt);
      end
`ifdef IF_ALIGN_CHECK_EN
      m_mis = |alt[1:0];
`endif
    end else begin
      do_pop  = (sb.size() != 0) && !st;
      do_push = (sb.size() != DEPTH) && h;
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        sb.push_back('{instr: ins, pc: m_pc});
        m_pc = m_pc + INCR;
      end
    end
  endtask

  initial begin
    // Outputs while held in reset
    #12;
    check("rst_valid", 32'(Instr_Valid_OUT), 32'h0);
    check("rst_instr", Instr1_OUT, 32'h0);
    check("rst_pc", Instr_PC_OUT, 32'h0);
    check("rst_plus4", Instr_PC_Plus4, INCR);
    check("rst_addr", Instr_address_2IM, RPC);
    check("rst_mis", 32'(Misaligned_OUT), 32'h0);
    @(negedge CLK);
    RESET = 1'b1;

    // Sequential fetch with continuous consumption
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    // Fill under stall, hold when full, then drain in order
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    // Full queue released with hit: no bypass, then steady push+pop
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    // Redirect with three entries queued
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h00400020);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    // Intermittent hit
    for (int i = 0; i < 6; i++) step(1'(i % 2 == 0), 1'b0, 1'b0, 32'h0);
    // Misaligned redirect, then aligned redirect without hit, and a stalled redirect
    step(1'b1, 1'b0, 1'b1, 32'h00400022);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h00400040);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 15) == 0), $urandom);
    end
    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge CLK);
    hit = 1'b0; STALL = 1'b0; Request_Alt_PC = 1'b0;
    #2 RESET = 1'b0;
    #1;
    check("mid_rst_valid", 32'(Instr_Valid_OUT), 32'h0);
    check("mid_rst_addr", Instr_address_2IM, RPC);
    check("mid_rst_mis", 32'(Misaligned_OUT), 32'h0);
    sb.delete();
    m_pc  = RPC;
    m_mis = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
